cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one line-wide memory port between the instruction-side and data-side caches.
//  Serialises line refills (read) and dirty-line write-backs (write) from both caches.
//  Arbitrates round-robin, with an optional lock so an evict-then-refill pair runs back to back.
//  Runs a watchdog that aborts memory transactions which never complete.
// PARAMETERS
//  LINE_BYTES  16   cache line size in bytes; LW = LINE_BYTES*8 is the line width in bits
//  TIMEOUT     255  max cycles in BUS waiting for mem_ack before abort; 0 disables the watchdog
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst_n       in   1   reset, asynchronous, active-low
//  r0_req      in   1   I-cache request, level; hold until r0_ack
//  r0_we       in   1   1=write-back line, 0=refill line
//  r0_lock     in   1   keep priority for the next r0 request
//  r0_addr     in   32  byte address; low log2(LINE_BYTES) bits ignored
//  r0_wdata    in   LW  write-back line data
//  r0_ack      out  1   1-cycle completion pulse
//  r0_err      out  1   valid with r0_ack; 1 = timed out
//  r0_rdata    out  LW  refill data, valid with r0_ack
//  r1_*        -    -   identical set for the D-cache (r1_req .. r1_rdata)
//  mem_req     out  1   memory transaction request, held until mem_ack
//  mem_we      out  1   1=write, 0=read
//  mem_addr    out  32  line-aligned address
//  mem_wdata   out  LW  line write data
//  mem_rdata   in   LW  line read data, valid with mem_ack
//  mem_ack     in   1   1-cycle completion from memory
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, state=IDLE, wdog=0
//   - last_grant=1, so r0 wins the first tie; lock_owner=none
//   - reset mid-transaction drops mem_req at once; no ack is issued for the aborted request
//  FSM states: IDLE, BUS, RESP.
//  IDLE:
//   - if lock_owner=rX and rX_req=1, grant rX
//   - else if exactly one req is high, grant it
//   - else if both are high, grant the requester != last_grant
//   - on grant: register gnt, we, addr with low bits zeroed, and wdata; next state BUS
//   - mem_req=1 from the first BUS cycle
//  BUS:
//   - mem_req, mem_we, mem_addr, mem_wdata held stable
//   - wdog increments every cycle without mem_ack
//   - mem_ack=1: capture mem_rdata into the response register (zero it if we=1); err=0; next state RESP
//   - TIMEOUT!=0 and wdog==TIMEOUT-1 without mem_ack: drop mem_req, rdata=0, err=1, next state RESP
//   - mem_ack and timeout in the same cycle: mem_ack wins
//  RESP:
//   - mem_req=0
//   - rG_ack=1 for exactly one cycle, with rG_err and rG_rdata
//   - update last_grant=G; lock_owner=G if rG_lock=1, else none; wdog=0
//   - next state IDLE
//  Response hold: rX_rdata and rX_err hold their values until the next ack to that requester.
//  Requester rule:
//   - rX_req must be low at the edge after the rX_ack cycle; it may reassert one cycle later
//   - reqs are sampled only in IDLE, so a req held high is treated as a new request
//  Latency:
//   - mem_req rises one cycle after req is sampled in IDLE
//   - with mem_ack in the first BUS cycle, rX_ack is high 2 cycles after the IDLE sample
//   - no back-to-back acks; throughput is at most 1 line per 3 cycles
//  Lock: honoured only in the first IDLE cycle after RESP; if rX_req is low there, lock_owner clears.
//  Fields of the non-granted requester are ignored; its req stays pending, since it is a level.
// TESTING
//  1. r0_req=1, we=0, addr=0x1234_5678; mem_ack in 1st BUS cycle, rdata=0xA5.. -> mem_addr=0x1234_5670, mem_we=0; r0_ack 2 cyc after sample, r0_rdata=0xA5.., err=0
//  2. r0_req and r1_req rise together from reset -> r0 served first, then r1; a second tie -> r0 again (RR)
//  3. r1 writeback with r1_lock=1, then r1 refill while r0_req is high -> r1 refill granted before r0
//  4. TIMEOUT=4, memory never acks -> mem_req high exactly 4 cycles, then r0_ack=1, r0_err=1, r0_rdata=0
//  5. mem_ack in the same cycle the watchdog expires -> err=0, data captured
//  6. rst_n low mid-BUS -> mem_req=0 asynchronously; no ack; after release r0 wins the tie

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache (r0) and D-cache (r1),
// with an evict-then-refill lock and a watchdog that aborts memory transactions that never ack.
//   state  | meaning
//   IDLE   | sample requests, pick a winner, latch its command
//   BUS    | mem_req held until mem_ack or watchdog expiry
//   RESP   | one-cycle ack to the winner, update round-robin and lock
module cache_mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT    = 255,
  localparam int LW        = LINE_BYTES * 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [31:0]   r0_addr,
  input  logic [LW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [LW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [31:0]   r1_addr,
  input  logic [LW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [LW-1:0] r1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [LW-1:0] mem_wdata,
  input  logic [LW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t          state, state_nxt;
  logic            gnt_sel, any_req, wd_expire;
  logic            gnt_q, we_q, last_grant, lock_vld, lock_id;
  logic [31:0]     addr_q;
  logic [LW-1:0]   wdata_q, cap_rdata;
  logic [WW-1:0]   wdog;

  assign any_req   = r0_req | r1_req;
  assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);
  // mem_ack beats a simultaneous expiry; write-backs return no data
  assign cap_rdata = (mem_ack && !we_q) ? mem_rdata : '0;

  always_comb begin
    gnt_sel = ~last_grant;
    if (lock_vld && !lock_id && r0_req)      gnt_sel = 1'b0;
    else if (lock_vld && lock_id && r1_req)  gnt_sel = 1'b1;
    else if (r0_req && !r1_req)              gnt_sel = 1'b0;
    else if (r1_req && !r0_req)              gnt_sel = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_BUS;
      S_BUS:   if (mem_ack || wd_expire) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    case (state)
      S_BUS: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      S_RESP: begin
        r0_ack = ~gnt_q;
        r1_ack = gnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdog       <= '0;
      last_grant <= 1'b1;
      lock_vld   <= 1'b0;
      lock_id    <= 1'b0;
      r0_rdata   <= '0;
      r0_err     <= 1'b0;
      r1_rdata   <= '0;
      r1_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // the lock only survives the first IDLE cycle after RESP
          lock_vld <= 1'b0;
          wdog     <= '0;
          if (any_req) begin
            gnt_q   <= gnt_sel;
            we_q    <= gnt_sel ? r1_we : r0_we;
            addr_q  <= (gnt_sel ? r1_addr : r0_addr) & ADDR_MASK;
            wdata_q <= gnt_sel ? r1_wdata : r0_wdata;
          end
        end
        S_BUS: begin
          if (mem_ack || wd_expire) begin
            if (gnt_q) begin
              r1_rdata <= cap_rdata;
              r1_err   <= ~mem_ack;
            end else begin
              r0_rdata <= cap_rdata;
              r0_err   <= ~mem_ack;
            end
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        S_RESP: begin
          last_grant <= gnt_q;
          lock_vld   <= gnt_q ? r1_lock : r0_lock;
          lock_id    <= gnt_q;
          wdog       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed table of arbitration rounds, randomized rounds
// against a request-level reference model, and a mid-transaction reset sequence.
module tb_cache_mem_arbiter;

  localparam int TO = 4;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          t_req [2];
  logic          t_we  [2];
  logic          t_lock[2];
  logic [31:0]   t_addr[2];
  logic [LW-1:0] t_wdata[2];
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic          r0_ack, r0_err, r1_ack, r1_err;
  logic [LW-1:0] r0_rdata, r1_rdata;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;

  int tests = 0;
  int fails = 0;

  int            last_g;
  int            lock_own;
  logic [LW-1:0] held_rd[2];
  logic          held_er[2];

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_BYTES(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(t_req[0]), .r0_we(t_we[0]), .r0_lock(t_lock[0]), .r0_addr(t_addr[0]),
    .r0_wdata(t_wdata[0]), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(t_req[1]), .r1_we(t_we[1]), .r1_lock(t_lock[1]), .r1_addr(t_addr[1]),
    .r1_wdata(t_wdata[1]), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [1:0]  raise;
    logic [1:0]  we;
    logic [1:0]  lk;
    logic [31:0] a0;
    logic [31:0] a1;
    int          idle;
    int          d;
    int          w;
    int          n;
    logic        e;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int predict();
    if (lock_own >= 0 && t_req[lock_own]) return lock_own;
    if (t_req[0] && !t_req[1]) return 0;
    if (t_req[1] && !t_req[0]) return 1;
    return 1 - last_g;
  endfunction

  function automatic void model_reset();
    last_g   = 1;
    lock_own = -1;
    held_rd[0] = '0; held_rd[1] = '0;
    held_er[0] = 1'b0; held_er[1] = 1'b0;
  endfunction

  // Called in an IDLE cycle with requests already presented; returns in the next first-IDLE cycle.
  task automatic round(input int d, input logic [LW-1:0] rd, input int w, input int en, input logic ee);
    int n;
    logic [LW-1:0] exp_rd;
    mem_rdata = ~rd;
    @(posedge clk); #1;
    lock_own = -1;
    chk("mem_req_rise", mem_req, 1);
    chk("mem_addr", mem_addr, t_addr[w] & ~32'hF);
    chk("mem_we", mem_we, t_we[w]);
    chk("mem_wdata", mem_wdata, t_wdata[w]);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      if (n == d) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      n++;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = ~rd;
    end
    chk("bus_cycles", n, en);
    exp_rd = (ee || t_we[w]) ? '0 : rd;
    chk("ack_winner", (w == 1) ? r1_ack : r0_ack, 1);
    chk("ack_other", (w == 1) ? r0_ack : r1_ack, 0);
    chk("err", (w == 1) ? r1_err : r0_err, ee);
    chk("rdata", (w == 1) ? r1_rdata : r0_rdata, exp_rd);
    chk("held_rdata", (w == 1) ? r0_rdata : r1_rdata, held_rd[1-w]);
    chk("held_err", (w == 1) ? r0_err : r1_err, held_er[1-w]);
    held_rd[w] = exp_rd;
    held_er[w] = ee;
    last_g     = w;
    lock_own   = t_lock[w] ? w : -1;
    t_req[w]   = 1'b0;
    @(posedge clk); #1;
    chk("no_back_to_back", r0_ack | r1_ack, 0);
    chk("mem_req_idle", mem_req, 0);
  endtask

  initial begin
    tbl[0] = '{2'b11, 2'b00, 2'b00, 32'h1234_5678, 32'h0000_1004, 0, 0, 0, 1, 1'b0};
    tbl[1] = '{2'b00, 2'b00, 2'b00, 32'h1111_1110, 32'h2222_2228, 0, 1, 1, 2, 1'b0};
    tbl[2] = '{2'b11, 2'b01, 2'b00, 32'hA000_000F, 32'hB000_0010, 0, 0, 0, 1, 1'b0};
    tbl[3] = '{2'b00, 2'b10, 2'b10, 32'h0000_0000, 32'hC000_0030, 0, 2, 1, 3, 1'b0};
    tbl[4] = '{2'b11, 2'b00, 2'b00, 32'hD000_0040, 32'hE000_0050, 0, 0, 1, 1, 1'b0};
    tbl[5] = '{2'b00, 2'b00, 2'b00, 32'hF000_0060, 32'h0000_0001, 0, 9, 0, 4, 1'b1};
    tbl[6] = '{2'b10, 2'b00, 2'b00, 32'h0000_0010, 32'h0000_0020, 0, 3, 1, 4, 1'b0};
    tbl[7] = '{2'b01, 2'b00, 2'b01, 32'h0000_0030, 32'h0000_0040, 0, 0, 0, 1, 1'b0};
    tbl[8] = '{2'b11, 2'b00, 2'b00, 32'h0000_0050, 32'h0000_0060, 1, 1, 1, 2, 1'b0};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 32'h0000_0070, 32'h0000_0080, 0, 0, 0, 1, 1'b0};

    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int j = 0; j < 2; j++) begin
      t_req[j] = 1'b0; t_we[j] = 1'b0; t_lock[j] = 1'b0; t_addr[j] = '0; t_wdata[j] = '0;
    end
    model_reset();
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {r0_ack, r1_ack, r0_err, r1_err}, 0);
    chk("rst_rdata", r0_rdata | r1_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].idle) begin
        @(posedge clk); #1;
        lock_own = -1;
      end
      for (int j = 0; j < 2; j++) begin
        t_req[j]   = t_req[j] | tbl[i].raise[j];
        t_we[j]    = tbl[i].we[j];
        t_lock[j]  = tbl[i].lk[j];
        t_wdata[j] = rnd128();
      end
      t_addr[0] = tbl[i].a0;
      t_addr[1] = tbl[i].a1;
      round(tbl[i].d, (i == 0) ? {16{8'hA5}} : rnd128(), tbl[i].w, tbl[i].n, tbl[i].e);
    end

    for (int k = 0; k < 40; k++) begin
      int d, w, en;
      logic ee;
      if (!t_req[0] && !t_req[1] && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        lock_own = -1;
      end
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 1) == 1) t_req[j] = 1'b1;
        t_we[j]    = 1'($urandom_range(0, 1));
        t_lock[j]  = 1'($urandom_range(0, 1));
        t_addr[j]  = $urandom;
        t_wdata[j] = rnd128();
      end
      if (!t_req[0] && !t_req[1]) t_req[$urandom_range(0, 1)] = 1'b1;
      w  = predict();
      d  = $urandom_range(0, 5);
      en = (d < TO) ? d + 1 : TO;
      ee = (d >= TO);
      round(d, rnd128(), w, en, ee);
    end

    t_req[0] = 1'b0;
    t_req[1] = 1'b0;
    t_addr[0] = 32'h0BAD_0000;
    @(posedge clk); #1;
    t_req[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_bus", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_mem_req", mem_req, 0);
    t_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    begin
      logic seen;
      seen = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        seen = seen | r0_ack | r1_ack;
      end
      chk("no_ack_after_reset", seen, 0);
      chk("rst_held_rdata", r0_rdata | r1_rdata, 0);
    end
    t_req[0] = 1'b1; t_req[1] = 1'b1;
    t_we[0] = 1'b0;  t_we[1] = 1'b0;
    t_lock[0] = 1'b0; t_lock[1] = 1'b0;
    t_addr[0] = 32'h4000_0004; t_addr[1] = 32'h5000_0008;
    round(0, rnd128(), 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
